// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF, DM and DBG accesses onto one single-port memory.
// Define ARB_STATS_EN to add saturating grant/conflict counters.
module mem_port_arbiter #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic          if_we,
    input  logic [AW-1:0] if_addr,
    input  logic [DW-1:0] if_wdata,
    output logic          if_gnt,
    output logic          if_rvalid,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,

    output logic [DW-1:0] rdata,
    input  logic          dbg_lock,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_if_gnt,
    output logic [15:0]   stat_dm_gnt,
    output logic [15:0]   stat_dbg_gnt,
    output logic [15:0]   stat_conflict
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    logic [1:0]    state_q, state_d;
    logic [2:0]    owner_q, owner_d;   // one-hot {DBG, DM, IF}
    logic          last_if_q, last_if_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          acc_we_q, acc_we_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    rvalid_q, rvalid_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          vis_if, vis_dm;
    logic [2:0]    win_oh;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign vis_if = if_req & ~dbg_lock;
    assign vis_dm = dm_req & ~dbg_lock;

    // DBG has fixed priority; IF/DM alternate on the last-winner bit.
    always_comb begin
        win_oh = 3'b000;
        if (dbg_req) begin
            win_oh = 3'b100;
        end else if (vis_if && vis_dm) begin
            win_oh = last_if_q ? 3'b010 : 3'b001;
        end else if (vis_if) begin
            win_oh = 3'b001;
        end else if (vis_dm) begin
            win_oh = 3'b010;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (win_oh)
            3'b001: begin
                sel_we    = if_we;
                sel_addr  = if_addr;
                sel_wdata = if_wdata;
            end
            3'b010: begin
                sel_we    = dm_we;
                sel_addr  = dm_addr;
                sel_wdata = dm_wdata;
            end
            3'b100: begin
                sel_we    = dbg_we;
                sel_addr  = dbg_addr;
                sel_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_if_d   = last_if_q;
        cnt_d       = cnt_q;
        acc_we_d    = acc_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        gnt_d       = 3'b000;
        rvalid_d    = 3'b000;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (win_oh != 3'b000) begin
                    state_d     = ST_ISSUE;
                    owner_d     = win_oh;
                    gnt_d       = win_oh;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    acc_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    if (!win_oh[2]) begin
                        last_if_d = win_oh[0];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = LAT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d  = ST_RESP;
                    rvalid_d = owner_q;
                    rdata_d  = acc_we_q ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 3'b000;
            last_if_q   <= 1'b1;
            cnt_q       <= 3'd0;
            acc_we_q    <= 1'b0;
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_if_q   <= last_if_d;
            cnt_q       <= cnt_d;
            acc_we_q    <= acc_we_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign if_gnt     = gnt_q[0];
    assign dm_gnt     = gnt_q[1];
    assign dbg_gnt    = gnt_q[2];
    assign if_rvalid  = rvalid_q[0];
    assign dm_rvalid  = rvalid_q[1];
    assign dbg_rvalid = rvalid_q[2];
    assign rdata      = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] st_if_q, st_if_d;
    logic [15:0] st_dm_q, st_dm_d;
    logic [15:0] st_dbg_q, st_dbg_d;
    logic [15:0] st_conf_q, st_conf_d;
    logic        arb_edge;
    logic [1:0]  n_vis;

    assign arb_edge = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign n_vis    = {1'b0, dbg_req} + {1'b0, vis_if} + {1'b0, vis_dm};

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        st_if_d   = sat_inc(st_if_q, arb_edge & win_oh[0]);
        st_dm_d   = sat_inc(st_dm_q, arb_edge & win_oh[1]);
        st_dbg_d  = sat_inc(st_dbg_q, arb_edge & win_oh[2]);
        st_conf_d = sat_inc(st_conf_q, arb_edge & (n_vis >= 2'd2));
        if (stat_clr) begin
            st_if_d   = '0;
            st_dm_d   = '0;
            st_dbg_d  = '0;
            st_conf_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_if_q   <= '0;
            st_dm_q   <= '0;
            st_dbg_q  <= '0;
            st_conf_q <= '0;
        end else begin
            st_if_q   <= st_if_d;
            st_dm_q   <= st_dm_d;
            st_dbg_q  <= st_dbg_d;
            st_conf_q <= st_conf_d;
        end
    end

    assign stat_if_gnt   = st_if_q;
    assign stat_dm_gnt   = st_dm_q;
    assign stat_dbg_gnt  = st_dbg_q;
    assign stat_conflict = st_conf_q;
`endif

endmodule
